aes_stream_framer: RTL

- Byte-stream front/back end for the combinational AES cipher core.
- Collects key bytes and 16-byte plaintext blocks from an 8-bit valid/ready stream, then presents the 128-bit block and N-bit key to the cipher.
- After a programmable settle time, captures the cipher result and streams the 16 ciphertext bytes out MSB-first on a second valid/ready stream.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_byte_serializer.sv | 63 ++++++
 rtl/aes_stream_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_pkg: shared types and constants for the AES stream framer      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package aes_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    EMIT    = 2'd2
  } state_e;

  function automatic int KEY_BYTES(input int n);
    return n / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_byte_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_byte_serializer: 128-bit load, MSB-first byte valid/ready out  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module aes_byte_serializer
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] data_i,
  input  logic         m_ready_i,
  output logic         m_valid_o,
  output logic [7:0]   m_data_o,
  output logic         m_last_o,
  output logic         done_o
);

  logic [127:0] out_q, out_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         w_hs;

  assign w_hs      = valid_q && m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = out_q[127:120];
  assign m_last_o  = (cnt_q == 4'(BLOCK_BYTES - 1));
  assign done_o    = w_hs && m_last_o;

  always_comb begin
    out_d   = out_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      out_d   = data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (w_hs) begin
      out_d = {out_q[119:0], 8'h00};
      if (m_last_o) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_stream_framer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_stream_framer: byte-stream framing around a combinational AES  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module aes_stream_framer
  import aes_pkg::*;
#(
  parameter int N          = 128,
  parameter int CIPHER_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [7:0]     s_data,
  input  logic           s_key_sel,
  output logic [127:0]   cipher_in,
  output logic [N-1:0]   cipher_key,
  input  logic [127:0]   cipher_out,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [7:0]     m_data,
  output logic           m_last,
  output logic           key_valid,
  output logic           busy
);

  localparam int c_key_bytes = KEY_BYTES(N);
  localparam int c_kcnt_w    = $clog2(c_key_bytes);
  localparam int c_wcnt_w    = (CIPHER_LAT > 1) ? $clog2(CIPHER_LAT) : 1;

  state_e                state_q, state_d;
  logic [3:0]            blk_cnt_q, blk_cnt_d;
  logic [c_kcnt_w-1:0]   key_cnt_q, key_cnt_d;
  logic [c_wcnt_w-1:0]   wait_cnt_q, wait_cnt_d;
  logic [127:0]          blk_q, blk_d;
  logic [N-1:0]          key_q, key_d;
  logic                  key_valid_q, key_valid_d;
  logic                  w_load;
  logic                  w_done;

  assign cipher_in  = blk_q;
  assign cipher_key = key_q;
  assign key_valid  = key_valid_q;
  assign busy       = (state_q != COLLECT);

  always_comb begin
    state_d     = state_q;
    blk_cnt_d   = blk_cnt_q;
    key_cnt_d   = key_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    blk_d       = blk_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    s_ready     = 1'b0;
    w_load      = 1'b0;
    case (state_q)
      COLLECT: begin
        // Key bytes are always accepted; data waits until a full key exists.
        s_ready = s_key_sel | key_valid_q;
        if (s_valid && s_ready) begin
          if (s_key_sel) begin
            key_d = {key_q[N-9:0], s_data};
            if ((key_cnt_q == '0) && key_valid_q) begin
              key_valid_d = 1'b0;
            end
            if (key_cnt_q == c_kcnt_w'(c_key_bytes - 1)) begin
              key_cnt_d   = '0;
              key_valid_d = 1'b1;
            end else begin
              key_cnt_d = key_cnt_q + 1'b1;
            end
          end else begin
            blk_d = {blk_q[119:0], s_data};
            if (blk_cnt_q == 4'(BLOCK_BYTES - 1)) begin
              blk_cnt_d  = '0;
              wait_cnt_d = '0;
              state_d    = WAIT;
            end else begin
              blk_cnt_d = blk_cnt_q + 4'd1;
            end
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == c_wcnt_w'(CIPHER_LAT - 1)) begin
          w_load     = 1'b1;
          wait_cnt_d = '0;
          state_d    = EMIT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (w_done) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      blk_cnt_q   <= '0;
      key_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_cnt_q   <= blk_cnt_d;
      key_cnt_q   <= key_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  aes_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (w_load),
    .data_i    (cipher_out),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .done_o    (w_done)
  );

endmodule
`default_nettype wire
